// File: rtl/onchip_mem_pkg.sv
// Shared definitions for the two-master on-chip RAM arbiter.
//   - Default widths and the implemented RAM depth.
//   - Value returned for reads that fall outside the implemented RAM.
//   - Read-tag struct carried from the accept edge to the response cycle.
package onchip_mem_pkg;

  localparam int ADDR_W_DEF    = 15;
  localparam int DATA_W_DEF    = 32;
  localparam int BE_W_DEF      = 4;
  localparam int NUM_WORDS_DEF = 32000;

  // Data returned for an accepted read whose address is beyond NUM_WORDS.
  localparam logic [31:0] OOB_READ_VALUE = 32'h0;

  // One outstanding read response: valid, which master owns it, and
  // whether the address missed the RAM.
  typedef struct packed {
    logic valid;
    logic owner;
    logic oob;
  } rd_tag_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with a combinational grant.
// Ports:
//   clk    - clock
//   reset  - asynchronous active-high reset
//   req    - request vector, bit N = master N
//   grant  - one-hot (or zero) grant vector, same cycle as req
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  // Pointer records the master granted last: 1 = m0, 0 = m1.
  // Reset value 0 ("m1 last") lets m0 win the first tie.
  logic pointer_reg;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = pointer_reg ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pointer_reg <= 1'b0;
    end else if (|grant) begin
      pointer_reg <= grant[0];
    end
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares one single-port on-chip RAM between two masters with round-robin
// arbitration, one access per cycle and a fixed 1-cycle read latency.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   mN_*                - master N request (address/byteenable/read/write/
//                         writedata) and response (waitrequest/readdata/
//                         readdatavalid), N = 0,1
//   mem_*               - RAM side: address, byteenable, chipselect, write,
//                         writedata, clken (outputs) and readdata (input,
//                         valid one cycle after a read issue)
module onchip_mem_arbiter
  import onchip_mem_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BE_W      = BE_W_DEF,
  parameter int NUM_WORDS = NUM_WORDS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  // Master ports gathered into arrays so per-master logic is generated once.
  logic [ADDR_W-1:0] address   [2];
  logic [BE_W-1:0]   byteenable[2];
  logic [DATA_W-1:0] writedata [2];
  logic [1:0]        rd;
  logic [1:0]        wr;
  logic [1:0]        requesting;
  logic [1:0]        grant;
  logic [1:0]        waitreq;
  logic [1:0]        rdvalid;
  logic [DATA_W-1:0] rddata    [2];

  assign address[0]    = m0_address;
  assign address[1]    = m1_address;
  assign byteenable[0] = m0_byteenable;
  assign byteenable[1] = m1_byteenable;
  assign writedata[0]  = m0_writedata;
  assign writedata[1]  = m1_writedata;
  assign rd            = {m1_read, m0_read};
  assign wr            = {m1_write, m0_write};

  rd_tag_t tag_reg;
  rd_tag_t tag_next;
  logic    clken_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_master
      // Requests are masked during reset so nothing is granted and no
      // waitrequest is raised while the block is held in reset.
      assign requesting[gi] = (rd[gi] | wr[gi]) & ~reset;
      assign waitreq[gi]    = requesting[gi] & ~grant[gi];
      assign rdvalid[gi]    = tag_reg.valid & (tag_reg.owner == 1'(gi));
      assign rddata[gi]     = !rdvalid[gi] ? '0 :
                              (tag_reg.oob ? DATA_W'(OOB_READ_VALUE) : mem_readdata);
    end
  endgenerate

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (requesting),
    .grant (grant)
  );

  logic sel;
  logic any_grant;
  logic sel_oob;

  assign sel       = grant[1];
  assign any_grant = |grant;
  assign sel_oob   = 32'(address[sel]) >= 32'(NUM_WORDS);

  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    tag_next       = '0;
    if (any_grant) begin
      mem_address    = address[sel];
      mem_byteenable = byteenable[sel];
      mem_writedata  = writedata[sel];
      // Out-of-range accesses are accepted but never touch the RAM; the
      // write strobe is held off too so it cannot alias onto a real word.
      mem_chipselect = ~sel_oob;
      mem_write      = wr[sel] & ~sel_oob;
      // Write wins over a simultaneous read, so only pure reads get a tag.
      tag_next.valid = ~wr[sel];
      tag_next.owner = sel;
      tag_next.oob   = sel_oob;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_reg   <= '0;
      clken_reg <= 1'b0;
    end else begin
      tag_reg   <= tag_next;
      clken_reg <= 1'b1;
    end
  end

  assign mem_clken        = clken_reg;
  assign m0_waitrequest   = waitreq[0];
  assign m1_waitrequest   = waitreq[1];
  assign m0_readdatavalid = rdvalid[0];
  assign m1_readdatavalid = rdvalid[1];
  assign m0_readdata      = rddata[0];
  assign m1_readdata      = rddata[1];

endmodule
